// File: rtl/mem_responder_if.sv
// mem_responder_if -- core-side memory bus for mem_responder.
//   core_to_mem_address      24-bit word address (core -> memory)
//   core_to_mem_data         16-bit write data (core -> memory)
//   core_to_mem_write_enable 1 = write this cycle (core -> memory)
//   mem_to_core_data         16-bit registered read data (memory -> core)
// Modports: master = core side, slave = memory side.
interface mem_responder_if;
  logic [23:0] core_to_mem_address;
  logic [15:0] core_to_mem_data;
  logic        core_to_mem_write_enable;
  logic [15:0] mem_to_core_data;

  modport master (
    output core_to_mem_address, core_to_mem_data, core_to_mem_write_enable,
    input  mem_to_core_data
  );
  modport slave (
    input  core_to_mem_address, core_to_mem_data, core_to_mem_write_enable,
    output mem_to_core_data
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder -- word RAM plus a small MMIO window behind one core bus.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (RAM contents are kept)
//   bus        mem_responder_if.slave: address / write data / write enable in,
//              one-cycle registered read data out
//   switches   asynchronous board switches (2-flop synchronized)
//   leds       LED register contents
//   bus_error  sticky flag, set by any access outside RAM and MMIO
// Address map: RAM at [0, 2^RAM_AW), MMIO window of 256 words at MMIO_BASE
//   0x00 leds (rw), 0x01 switches (ro), 0x02 timer[15:0], 0x03 timer high
//   shadow (ro), 0x04 status (bit0 bus_error, write 1 to clear), others read 0.
// Optional feature: define MEM_RESPONDER_TIMER_EN to build the 32-bit timer
//   and its shadow; without it offsets 0x02/0x03 behave as empty offsets.
module mem_responder #(
  parameter int          RAM_AW    = 14,
  parameter logic [23:0] MMIO_BASE = 24'hFFFF00
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus,
  input  logic [15:0]     switches,
  output logic [15:0]     leds,
  output logic            bus_error
);
  localparam logic [24:0] RAM_TOP  = 25'(1) << RAM_AW;
  localparam logic [24:0] MMIO_LO  = {1'b0, MMIO_BASE};
  localparam logic [24:0] MMIO_HI  = {1'b0, MMIO_BASE} + 25'h0FF;

  logic [24:0]       addr;
  logic [7:0]        off;
  logic [RAM_AW-1:0] ram_idx;
  logic              we, ram_hit, mmio_hit;

  assign addr     = {1'b0, bus.core_to_mem_address};
  assign off      = bus.core_to_mem_address[7:0];
  assign ram_idx  = bus.core_to_mem_address[RAM_AW-1:0];
  assign we       = bus.core_to_mem_write_enable;
  assign ram_hit  = addr < RAM_TOP;
  assign mmio_hit = (addr >= MMIO_LO) && (addr <= MMIO_HI);

  logic [15:0] ram_q [2**RAM_AW];
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] leds_q, leds_d;
  logic        err_q, err_d, err_set, err_clr;
  logic [15:0] sync1_q, sync2_q;

  // RAM has no reset; gating with rst_n keeps a write that overlaps reset
  // from landing. The read mux samples ram_q before this edge (read-first).
  always_ff @(posedge clk) begin
    if (rst_n && we && ram_hit) ram_q[ram_idx] <= bus.core_to_mem_data;
  end

`ifdef MEM_RESPONDER_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic [15:0] shadow_q, shadow_d;

  // Reading the low half latches the high half so 0x02 then 0x03 is coherent.
  always_comb begin
    shadow_d = shadow_q;
    timer_d  = timer_q + 32'd1;
    if (mmio_hit && off == 8'h02) begin
      shadow_d = timer_q[31:16];
      if (we) timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      shadow_q <= '0;
    end else begin
      timer_q  <= timer_d;
      shadow_q <= shadow_d;
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    leds_d  = leds_q;
    err_set = 1'b0;
    err_clr = 1'b0;
    if (ram_hit) begin
      rdata_d = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (off)
        8'h00: begin
          rdata_d = leds_q;
          if (we) leds_d = bus.core_to_mem_data;
        end
        8'h01: rdata_d = sync2_q;
`ifdef MEM_RESPONDER_TIMER_EN
        8'h02: rdata_d = timer_q[15:0];
        8'h03: rdata_d = shadow_q;
`endif
        8'h04: begin
          rdata_d = {15'd0, err_q};
          err_clr = we && bus.core_to_mem_data[0];
        end
        default: rdata_d = '0;
      endcase
    end else begin
      err_set = 1'b1;
    end
    // Set beats clear if both ever land on one edge.
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      leds_q  <= '0;
      err_q   <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      leds_q  <= leds_d;
      err_q   <= err_d;
      sync1_q <= switches;
      sync2_q <= sync1_q;
    end
  end

  assign bus.mem_to_core_data = rdata_q;
  assign leds                 = leds_q;
  assign bus_error            = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- table vectors, hand sequences for multi-cycle corners,
// and a randomized run against a behavioural model of the memory map.
module tb_mem_responder;
  localparam int          RAM_AW = 14;
  localparam logic [23:0] MB     = 24'hFFFF00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] switches = '0;
  logic [15:0] leds;
  logic        bus_error;

  mem_responder_if bus();

  mem_responder #(.RAM_AW(RAM_AW), .MMIO_BASE(MB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .switches(switches), .leds(leds), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_ram [int];
  logic [15:0] m_leds;
  logic        m_err;
  logic [31:0] m_timer;
  logic [15:0] m_shadow;
  logic [15:0] sw_hist [$];
  logic [15:0] exp_rd;
  bit          exp_known;

  task automatic model_reset();
    m_leds = 0; m_err = 0; m_timer = 0; m_shadow = 0;
    sw_hist.delete();
  endtask

  // Expected read for this access from the pre-edge state, then commit.
  task automatic model(input logic [23:0] a, input logic [15:0] d, input logic we);
    int unsigned ai;
    int unsigned o;
    logic [15:0] sw_seen;
    ai = a;
    o = ai - MB;
    exp_rd = 0; exp_known = 1;
    sw_seen = (sw_hist.size() >= 2) ? sw_hist[sw_hist.size()-2] : 16'h0;
    if (ai < (1 << RAM_AW)) begin
      if (m_ram.exists(ai)) exp_rd = m_ram[ai];
      else exp_known = 0;
      if (we) m_ram[ai] = d;
      m_timer = m_timer + 1;
    end else if (ai >= MB && ai <= MB + 255) begin
      case (o)
        0: begin exp_rd = m_leds; if (we) m_leds = d; end
        1: exp_rd = sw_seen;
        4: begin exp_rd = {15'd0, m_err}; if (we && d[0]) m_err = 0; end
`ifdef MEM_RESPONDER_TIMER_EN
        2: exp_rd = m_timer[15:0];
        3: exp_rd = m_shadow;
`endif
        default: exp_rd = 0;
      endcase
`ifdef MEM_RESPONDER_TIMER_EN
      if (o == 2) m_shadow = m_timer[31:16];
      m_timer = (o == 2 && we) ? 32'd0 : m_timer + 1;
`else
      m_timer = m_timer + 1;
`endif
    end else begin
      m_err = 1;
      m_timer = m_timer + 1;
    end
    sw_hist.push_back(switches);
  endtask

  // One bus cycle: called at a negedge, returns at the next negedge.
  task automatic step(input logic [23:0] a, input logic [15:0] d, input logic we);
    model(a, d, we);
    bus.core_to_mem_address      = a;
    bus.core_to_mem_data         = d;
    bus.core_to_mem_write_enable = we;
    @(negedge clk);
    bus.core_to_mem_write_enable = 1'b0;
    bus.core_to_mem_address      = 24'h0;
  endtask

  typedef struct {
    logic [23:0] a;
    logic [15:0] d;
    logic        we;
    logic        chk_rd;
    logic [15:0] rd;
    logic [15:0] led;
    logic        err;
  } vec_t;

  vec_t vt [20];

  initial begin
    bus.core_to_mem_address      = 24'h0;
    bus.core_to_mem_data         = 16'h0;
    bus.core_to_mem_write_enable = 1'b0;
    model_reset();

    vt[0]  = '{24'h003C8C, 16'hBEEF, 1, 0, 16'h0000, 16'h0000, 0};
    vt[1]  = '{24'h003C8C, 16'h0000, 0, 1, 16'hBEEF, 16'h0000, 0};
    vt[2]  = '{24'h000010, 16'hAAAA, 1, 0, 16'h0000, 16'h0000, 0};
    vt[3]  = '{24'h000010, 16'h1234, 1, 1, 16'hAAAA, 16'h0000, 0};
    vt[4]  = '{24'h000010, 16'h0000, 0, 1, 16'h1234, 16'h0000, 0};
    vt[5]  = '{MB + 24'd0, 16'h00A5, 1, 1, 16'h0000, 16'h00A5, 0};
    vt[6]  = '{MB + 24'd0, 16'h0000, 0, 1, 16'h00A5, 16'h00A5, 0};
    vt[7]  = '{24'h800000, 16'h0000, 0, 1, 16'h0000, 16'h00A5, 1};
    vt[8]  = '{MB + 24'd4, 16'h0000, 0, 1, 16'h0001, 16'h00A5, 1};
    vt[9]  = '{MB + 24'd4, 16'h0001, 1, 1, 16'h0001, 16'h00A5, 0};
    vt[10] = '{MB + 24'd4, 16'h0000, 0, 1, 16'h0000, 16'h00A5, 0};
    vt[11] = '{MB + 24'd1, 16'hFFFF, 1, 1, 16'h0000, 16'h00A5, 0};
    vt[12] = '{MB + 24'd5, 16'hFFFF, 1, 1, 16'h0000, 16'h00A5, 0};
    vt[13] = '{24'h004000, 16'h5555, 1, 1, 16'h0000, 16'h00A5, 1};
    vt[14] = '{MB + 24'd4, 16'h0001, 1, 1, 16'h0001, 16'h00A5, 0};
    vt[15] = '{24'h003FFF, 16'h0F0F, 1, 0, 16'h0000, 16'h00A5, 0};
    vt[16] = '{24'h003FFF, 16'h0000, 0, 1, 16'h0F0F, 16'h00A5, 0};
    vt[17] = '{MB - 24'd1, 16'h0000, 0, 1, 16'h0000, 16'h00A5, 1};
    vt[18] = '{MB + 24'd4, 16'h0000, 1, 1, 16'h0001, 16'h00A5, 1};
    vt[19] = '{MB + 24'd4, 16'h0001, 1, 1, 16'h0001, 16'h00A5, 0};

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_rdata", 32'(bus.mem_to_core_data), 32'h0);
    chk("reset_leds", 32'(leds), 32'h0);
    chk("reset_err", 32'(bus_error), 32'h0);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 20; i++) begin
      step(vt[i].a, vt[i].d, vt[i].we);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 32'(bus.mem_to_core_data), 32'(vt[i].rd));
      chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(vt[i].led));
      chk($sformatf("vec%0d_err", i), 32'(bus_error), 32'(vt[i].err));
    end

    // switch synchronizer latency
    switches = 16'h5A5A;
    repeat (3) step(24'h0, 16'h0, 0);
    step(MB + 24'd1, 16'h0, 0);
    chk("sw_read", 32'(bus.mem_to_core_data), 32'h5A5A);
    switches = 16'h1234;
    step(MB + 24'd1, 16'h0, 0);
    chk("sw_lag", 32'(bus.mem_to_core_data), 32'h5A5A);

`ifdef MEM_RESPONDER_TIMER_EN
    step(MB + 24'd2, 16'hDEAD, 1);
    repeat (5) step(24'h0, 16'h0, 0);
    step(MB + 24'd2, 16'h0, 0);
    chk("timer_after_load", 32'(bus.mem_to_core_data), 32'h0005);
    force dut.timer_q = 32'h0001FFFF;
    #1 release dut.timer_q;
    m_timer = 32'h0001FFFF;
    step(MB + 24'd2, 16'h0, 0);
    chk("timer_lo", 32'(bus.mem_to_core_data), 32'hFFFF);
    step(MB + 24'd3, 16'h0, 0);
    chk("timer_shadow", 32'(bus.mem_to_core_data), 32'h0001);
`else
    step(MB + 24'd2, 16'hFFFF, 1);
    step(MB + 24'd2, 16'h0, 0);
    chk("notimer_lo", 32'(bus.mem_to_core_data), 32'h0);
    step(MB + 24'd3, 16'hFFFF, 1);
    step(MB + 24'd3, 16'h0, 0);
    chk("notimer_hi", 32'(bus.mem_to_core_data), 32'h0);
`endif
    chk("timer_no_err", 32'(bus_error), 32'h0);

    // reset in the middle of a write to the LED register
    step(24'h000020, 16'h7777, 1);
    step(MB + 24'd0, 16'h00C3, 1);
    chk("leds_pre_reset", 32'(leds), 32'h00C3);
    bus.core_to_mem_address      = MB;
    bus.core_to_mem_data         = 16'hFFFF;
    bus.core_to_mem_write_enable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_leds", 32'(leds), 32'h0);
    chk("rst_async_rdata", 32'(bus.mem_to_core_data), 32'h0);
    @(negedge clk);
    chk("rst_write_blocked", 32'(leds), 32'h0);
    bus.core_to_mem_write_enable = 1'b0;
    bus.core_to_mem_address      = 24'h0;
    rst_n = 1'b1;
    model_reset();
`ifdef MEM_RESPONDER_TIMER_EN
    step(MB + 24'd2, 16'h0, 0);
    chk("rst_timer", 32'(bus.mem_to_core_data), 32'h0);
`endif
    step(24'h000020, 16'h0, 0);
    chk("ram_survives_reset", 32'(bus.mem_to_core_data), 32'h7777);

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      logic [23:0] a;
      logic [15:0] d;
      logic        we;
      int          cls;
      cls = $urandom_range(0, 9);
      d = 16'($urandom);
      we = 1'($urandom);
      switches = 16'($urandom);
      case (cls)
        0, 1, 2: a = 24'($urandom_range(0, 31));
        3:       a = 24'($urandom_range(16'h3FF0, 16'h3FFF));
        4, 5, 6: a = MB + 24'($urandom_range(0, 7));
        7:       a = MB + 24'($urandom_range(8, 255));
        8:       a = 24'($urandom_range(16'h4000, 24'hFFFEFF));
        default: a = (i % 2) ? MB - 24'd1 : 24'h004000;
      endcase
      step(a, d, we);
      if (exp_known) chk($sformatf("rnd%0d_rdata", i), 32'(bus.mem_to_core_data), 32'(exp_rd));
      chk($sformatf("rnd%0d_leds", i), 32'(leds), 32'(m_leds));
      chk($sformatf("rnd%0d_err", i), 32'(bus_error), 32'(m_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
